// File: rtl/mda_motor_control_multi.sv
// Multi-channel H-bridge PWM driver: one shared period counter, per-channel
// IDLE/DRIVE/DEAD state machines with dead time on every direction reversal.
module mda_motor_control_multi #(
  parameter int NUM_CH   = 4,
  parameter int PERIOD_W = 16,
  parameter int DEAD_CYC = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         update,
  input  logic [NUM_CH-1:0]            dir,
  input  logic [NUM_CH-1:0]            on,
  input  logic [PERIOD_W-1:0]          period,
  input  logic [NUM_CH*PERIOD_W-1:0]   duty_cycle,
  output logic [4*NUM_CH-1:0]          out,
  output logic                         update_pending,
  output logic                         period_start
);

  typedef enum logic [1:0] {IDLE, DRIVE, DEAD} state_t;

  localparam logic [7:0] DEAD_INIT = 8'(DEAD_CYC);

  logic [PERIOD_W-1:0]        cnt;
  logic [PERIOD_W-1:0]        period_act, period_pnd, period_nxt;
  logic [NUM_CH-1:0]          dir_act, dir_pnd, dir_nxt;
  logic [NUM_CH-1:0]          on_act, on_pnd, on_nxt;
  logic [NUM_CH*PERIOD_W-1:0] duty_act, duty_pnd, duty_nxt;
  logic                       boundary;

  assign boundary = (cnt == period_act);

  // Values that become active after this edge; an update in the boundary
  // cycle bypasses the pending registers so it takes effect immediately.
  always_comb begin
    period_nxt = period_act;
    dir_nxt    = dir_act;
    on_nxt     = on_act;
    duty_nxt   = duty_act;
    if (boundary && update) begin
      period_nxt = period;
      dir_nxt    = dir;
      on_nxt     = on;
      duty_nxt   = duty_cycle;
    end else if (boundary && update_pending) begin
      period_nxt = period_pnd;
      dir_nxt    = dir_pnd;
      on_nxt     = on_pnd;
      duty_nxt   = duty_pnd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt            <= '0;
      period_act     <= '0;
      period_pnd     <= '0;
      dir_act        <= '0;
      dir_pnd        <= '0;
      on_act         <= '0;
      on_pnd         <= '0;
      duty_act       <= '0;
      duty_pnd       <= '0;
      update_pending <= 1'b0;
      period_start   <= 1'b0;
    end else begin
      cnt          <= boundary ? '0 : cnt + 1'b1;
      period_start <= (cnt == '0);
      period_act   <= period_nxt;
      dir_act      <= dir_nxt;
      on_act       <= on_nxt;
      duty_act     <= duty_nxt;
      if (update) begin
        period_pnd <= period;
        dir_pnd    <= dir;
        on_pnd     <= on;
        duty_pnd   <= duty_cycle;
      end
      update_pending <= boundary ? 1'b0 : (update_pending | update);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    state_t     st, st_n;
    logic [7:0] dcnt, dcnt_n;
    logic       ddir, ddir_n, pwm;
    logic [3:0] gate, gate_n;

    assign pwm = (cnt < duty_act[g*PERIOD_W +: PERIOD_W]);

    always_comb begin
      st_n   = st;
      dcnt_n = dcnt;
      ddir_n = ddir;
      gate_n = 4'b0000;
      case (st)
        IDLE: begin
          if (boundary && on_nxt[g]) begin
            st_n   = DRIVE;
            ddir_n = dir_nxt[g];
          end
        end
        DRIVE: begin
          // {HA,LA,HB,LB}: the low side of the opposite leg stays on
          gate_n = ddir ? {pwm, 1'b0, 1'b0, 1'b1} : {1'b0, 1'b1, pwm, 1'b0};
          if (boundary && !on_nxt[g]) begin
            st_n = IDLE;
          end else if (boundary && (dir_nxt[g] != ddir)) begin
            st_n   = DEAD;
            dcnt_n = DEAD_INIT;
            ddir_n = dir_nxt[g];
          end
        end
        DEAD: begin
          if (boundary && (dir_nxt[g] != ddir)) begin
            dcnt_n = DEAD_INIT;
            ddir_n = dir_nxt[g];
          end else if (dcnt <= 8'd1) begin
            dcnt_n = 8'd0;
            st_n   = on_nxt[g] ? DRIVE : IDLE;
            ddir_n = dir_nxt[g];
          end else begin
            dcnt_n = dcnt - 8'd1;
          end
        end
        default: st_n = IDLE;
      endcase
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        st   <= IDLE;
        dcnt <= 8'd0;
        ddir <= 1'b0;
        gate <= 4'b0000;
      end else begin
        st   <= st_n;
        dcnt <= dcnt_n;
        ddir <= ddir_n;
        gate <= gate_n;
      end
    end

    assign out[4*g +: 4] = gate;
  end

endmodule

// File: tb/tb_mda_motor_control_multi.sv
// Directed bench for mda_motor_control_multi: PWM patterns, update timing,
// dead time on reversal, duty extremes, reset and period 0.
module tb_mda_motor_control_multi;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        update = 1'b0;
  logic [3:0]  dir = '0;
  logic [3:0]  on = '0;
  logic [15:0] period = '0;
  logic [63:0] duty_cycle = '0;
  logic [15:0] out;
  logic        update_pending;
  logic        period_start;

  int checks = 0;
  int failures = 0;

  mda_motor_control_multi dut (
    .clk(clk), .reset(reset), .update(update), .dir(dir), .on(on),
    .period(period), .duty_cycle(duty_cycle), .out(out),
    .update_pending(update_pending), .period_start(period_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Off channels carry nonzero duty and mixed dir to show they stay dark.
  task automatic do_update(input logic [15:0] p, input logic o0, input logic d0,
                           input logic [15:0] du);
    period     = p;
    on         = {3'b000, o0};
    dir        = {3'b101, d0};
    duty_cycle = {16'd5, 16'd5, 16'd5, du};
    update     = 1'b1;
    @(negedge clk);
    update     = 1'b0;
  endtask

  task automatic wait_ps();
    int n = 0;
    while (!period_start && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!period_start) chk("ps_timeout", period_start, 1);
  endtask

  // One 10-cycle period of channel 0 starting at a period_start sample.
  task automatic check_period(input string tag, input int duty, input logic fwd);
    logic [3:0] exp;
    for (int k = 0; k < 10; k++) begin
      if (fwd) exp = (k < duty) ? 4'b1001 : 4'b0001;
      else     exp = (k < duty) ? 4'b0110 : 4'b0100;
      chk(tag, out[3:0], exp);
      chk({tag, "_others"}, out[15:4], 0);
      if (k == 0) chk({tag, "_ps"}, period_start, 1);
      @(negedge clk);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      for (int c = 0; c < 4; c++) begin
        chk("shoot_a", out[4*c+3] & out[4*c+2], 0);
        chk("shoot_b", out[4*c+1] & out[4*c], 0);
      end
    end
  end

  initial begin
    int n;
    int z;
    repeat (2) @(negedge clk);
    chk("rst_out", out, 0);
    chk("rst_pend", update_pending, 0);
    chk("rst_ps", period_start, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("p0_ps_a", period_start, 1);
    @(negedge clk);
    chk("p0_ps_b", period_start, 1);

    // basic PWM; period_active is 0 so the update lands at once
    do_update(16'd9, 1'b1, 1'b1, 16'd3);
    chk("s1_pend_immediate", update_pending, 0);
    repeat (2) @(negedge clk);
    wait_ps();
    check_period("s1_fwd3_a", 3, 1'b1);
    check_period("s1_fwd3_b", 3, 1'b1);

    // duty extremes
    do_update(16'd9, 1'b1, 1'b1, 16'd0);
    chk("s3_pend0", update_pending, 1);
    wait_ps();
    check_period("s3_duty0", 0, 1'b1);
    do_update(16'd9, 1'b1, 1'b1, 16'd10);
    chk("s3_pend10", update_pending, 1);
    wait_ps();
    check_period("s3_duty10", 10, 1'b1);

    // two mid-period updates: the second one wins
    do_update(16'd9, 1'b1, 1'b1, 16'd5);
    chk("s4_pend_a", update_pending, 1);
    repeat (2) @(negedge clk);
    chk("s4_pend_hold", update_pending, 1);
    do_update(16'd9, 1'b1, 1'b1, 16'd7);
    chk("s4_pend_b", update_pending, 1);
    wait_ps();
    chk("s4_pend_clr", update_pending, 0);
    check_period("s4_duty7", 7, 1'b1);

    // update during the boundary cycle (counter == 9) applies at once
    repeat (8) @(negedge clk);
    do_update(16'd9, 1'b1, 1'b1, 16'd2);
    chk("s4_bnd_pend", update_pending, 0);
    wait_ps();
    check_period("s4_bnd_duty2", 2, 1'b1);

    // direction reversal with dead time
    do_update(16'd9, 1'b1, 1'b0, 16'd3);
    n = 0;
    while (out[3:0] !== 4'b0000 && n < 40) begin
      @(negedge clk);
      n++;
    end
    z = 0;
    while (out[3:0] === 4'b0000 && z < 100) begin
      z++;
      @(negedge clk);
    end
    chk("s2_dead_len", z, 32);
    chk("s2_first_rev", out[3:0], 4'b0110);
    wait_ps();
    check_period("s2_rev3", 3, 1'b0);

    // reset in the middle of dead time
    do_update(16'd9, 1'b1, 1'b1, 16'd3);
    n = 0;
    while (out[3:0] !== 4'b0000 && n < 40) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    do_update(16'd9, 1'b1, 1'b1, 16'd4);
    chk("s5_pend_set", update_pending, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("s5_dead_rst_out", out, 0);
    chk("s5_dead_rst_pend", update_pending, 0);
    chk("s5_dead_rst_ps", period_start, 0);
    reset = 1'b0;

    // reset in the middle of DRIVE
    do_update(16'd9, 1'b1, 1'b1, 16'd3);
    repeat (2) @(negedge clk);
    wait_ps();
    check_period("s5_after_rst", 3, 1'b1);
    chk("s5_pre_rst_out", out[3:0], 4'b1001);
    reset = 1'b1;
    @(negedge clk);
    chk("s5_drv_rst_out", out, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("s5_idle_out", out, 0);
    chk("s5_idle_ps", period_start, 1);

    // period 0: every cycle is a boundary
    do_update(16'd9, 1'b1, 1'b1, 16'd3);
    repeat (3) @(negedge clk);
    do_update(16'd0, 1'b1, 1'b1, 16'd3);
    wait_ps();
    for (int k = 0; k < 6; k++) begin
      chk("s5_p0_ps", period_start, 1);
      chk("s5_p0_out", out[3:0], 4'b1001);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mda_motor_control_multi.md
MDA_MOTOR_CONTROL_MULTI -- requirements
Module: mda_motor_control_multi

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent H-bridge channels (1..16).
REQ-002 Parameter PERIOD_W, default 16: width of the period counter, period and duty values.
REQ-003 Parameter DEAD_CYC, default 32: all-off cycles inserted on direction reversal (1..255).
REQ-004 Port clk, input, 1: single clock for all logic.
REQ-005 Port reset, input, 1: reset is synchronous and active-high.
REQ-006 Port update, input, 1: single-cycle request to capture dir/on/duty_cycle/period into pending registers.
REQ-007 Port dir, input, NUM_CH: per-channel direction, 1 = forward, 0 = reverse.
REQ-008 Port on, input, NUM_CH: per-channel enable.
REQ-009 Port period, input, PERIOD_W: shared PWM period; period length is period+1 cycles.
REQ-010 Port duty_cycle, input, NUM_CH*PERIOD_W: channel i duty in bits [i*PERIOD_W +: PERIOD_W], counted in on-cycles.
REQ-011 Port out, output, 4*NUM_CH: channel i MOSFET gates {HA,LA,HB,LB} in bits [4i+3:4i].
REQ-012 Port update_pending, output, 1: high while captured values await the next period boundary.
REQ-013 Port period_start, output, 1: one-cycle pulse in the cycle the counter equals 0.

Function
REQ-014 Shared counter SHALL count 0..period_active, then wrap to 0; the cycle where counter == period_active is the boundary.
REQ-015 update SHALL copy all inputs into pending registers on that edge and set update_pending; a second update before the boundary overwrites pending.
REQ-016 At the boundary edge with update_pending = 1, pending values SHALL load into active registers and update_pending SHALL clear.
REQ-017 update coinciding with the boundary cycle SHALL apply at that same boundary.
REQ-018 period_active = 0 SHALL make every cycle a boundary, with period_start constantly high.
REQ-019 Per-channel FSM states: IDLE, DRIVE, DEAD.
REQ-020 IDLE: out = 0000; at a boundary with on_active = 1, go to DRIVE with drive_dir = dir_active.
REQ-021 DRIVE: pwm = (counter < duty_active).
-- Forward: HA = pwm, LB = 1, LA = HB = 0.
-- Reverse: HB = pwm, LA = 1, HA = LB = 0.
REQ-022 DRIVE: at a boundary with on_active = 0, go to IDLE.
REQ-023 DRIVE: at a boundary with dir_active != drive_dir, go to DEAD and load the dead counter with DEAD_CYC.
REQ-024 DEAD: out = 0000; decrement the dead counter each cycle.
REQ-025 DEAD exit at count 0:
-- DRIVE with drive_dir = dir_active if on_active = 1;
-- otherwise IDLE.
REQ-026 DEAD: a further direction change at a boundary SHALL reload the dead counter.
REQ-027 duty_active = 0 SHALL give 0 % high-side on-time; duty_active > period_active SHALL give 100 %.
REQ-028 out SHALL be registered; out at cycle t+1 reflects counter and FSM state at cycle t; period_start is likewise registered.
REQ-029 No channel SHALL ever assert HA&LA or HB&LB in any cycle, including across state transitions.
REQ-030 Channels SHALL be fully independent except for the shared counter and period.

Reset
REQ-031 While reset is high at a clk edge, the block SHALL set:
-- counter = 0, all active and pending registers = 0, update_pending = 0;
-- every FSM to IDLE, dead counters = 0;
-- out = 0, period_start = 0.
REQ-032 Reset asserted mid-DEAD or mid-DRIVE SHALL force out = 0 on the next edge with no partial dead time carried over.

Verification
REQ-033 Scenario 1 (basic PWM):
-- Stimulus: NUM_CH = 4, update with period = 9, ch0 on = 1, dir = 1, duty = 3.
-- Response: each 10-cycle period, ch0 out = 1001 for 3 cycles and 0001 for 7 cycles; other channels 0000.
REQ-034 Scenario 2 (direction reversal):
-- Stimulus: ch0 driving forward, update dir = 0.
-- Response: at the boundary, exactly DEAD_CYC = 32 cycles of 0000, then 0110/0100 pattern.
-- Check: HA&LA or HB&LB never seen.
REQ-035 Scenario 3 (duty extremes):
-- duty = 0: ch0 constant 0001.
-- duty = 10 with period = 9: ch0 constant 1001.
REQ-036 Scenario 4 (update timing):
-- Stimulus: two updates mid-period, duty 5 then 7.
-- Response: update_pending high until the boundary; only duty 7 applied; update in the boundary cycle applies immediately.
REQ-037 Scenario 5 (reset and period 0):
-- Stimulus: assert reset during DEAD.
-- Response: out = 0 next cycle, update_pending = 0.
-- Stimulus: period = 0.
-- Response: period_start held high.
